// File: rtl/expansor_vizinhos.sv
// expansor_vizinhos: walks the neighbour list of the node being expanded,
// computes each candidate cost (node cost + edge weight) and hands every
// candidate to the active-node evaluator over a valid/ready handshake.
// Optional feature: define EXPANSOR_SATURACAO_EN to saturate candidate costs
// at all ones and raise the sticky saturou_out flag; otherwise costs wrap.
module expansor_vizinhos #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned COST_WIDTH   = 10,
  parameter int unsigned MAX_VIZINHOS = 8,
  parameter int unsigned IDX_WIDTH    = $clog2(MAX_VIZINHOS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            expandir_in,
  input  logic [ADDR_WIDTH-1:0]           no_atual_in,
  input  logic [COST_WIDTH-1:0]           custo_atual_in,
  output logic                            mem_rd_out,
  output logic [ADDR_WIDTH+IDX_WIDTH-1:0] mem_addr_out,
  input  logic                            mem_valido_in,
  input  logic [ADDR_WIDTH-1:0]           mem_vizinho_in,
  input  logic [COST_WIDTH-1:0]           mem_peso_in,
  output logic                            atualizar_out,
  output logic [ADDR_WIDTH-1:0]           atualizar_addr_out,
  output logic [COST_WIDTH-1:0]           atualizar_custo_out,
  output logic [ADDR_WIDTH-1:0]           atualizar_pai_out,
  input  logic                            aa_pronto_in,
  output logic                            ocupado_out,
  output logic                            lvv_pronto_out,
  output logic                            saturou_out
);

  typedef enum logic [2:0] {StIdle, StLer, StDado, StEnviar, StPronto} state_e;

  localparam logic [IDX_WIDTH-1:0] IdxLast = IDX_WIDTH'(MAX_VIZINHOS - 1);

  state_e                state_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  idx_nxt;
  logic [ADDR_WIDTH-1:0] no_q;
  logic [COST_WIDTH-1:0] custo_q;
  logic [COST_WIDTH-1:0] soma;

  assign idx_nxt = idx_q + 1'b1;

`ifdef EXPANSOR_SATURACAO_EN
  logic [COST_WIDTH:0] soma_ext;
  logic                carry;
  logic                saturou_q;

  // Candidate cost with one extra bit; a carry clamps the result to all ones
  always_comb begin
    soma_ext = {1'b0, custo_q} + {1'b0, mem_peso_in};
    carry    = soma_ext[COST_WIDTH];
    soma     = carry ? {COST_WIDTH{1'b1}} : soma_ext[COST_WIDTH-1:0];
  end

  // Sticky saturation flag: cleared by an accepted start, set by a saturated candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saturou_q <= 1'b0;
    end else if (state_q == StIdle && expandir_in) begin
      saturou_q <= 1'b0;
    end else if (state_q == StDado && mem_valido_in && carry) begin
      saturou_q <= 1'b1;
    end
  end

  assign saturou_out = saturou_q;
`else
  // Candidate cost wraps modulo 2^COST_WIDTH
  always_comb begin
    soma = custo_q + mem_peso_in;
  end

  assign saturou_out = 1'b0;
`endif

  // Sequencer FSM; every output is registered and set on entry to its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= StIdle;
      idx_q               <= '0;
      no_q                <= '0;
      custo_q             <= '0;
      mem_rd_out          <= 1'b0;
      mem_addr_out        <= '0;
      atualizar_out       <= 1'b0;
      atualizar_addr_out  <= '0;
      atualizar_custo_out <= '0;
      atualizar_pai_out   <= '0;
      ocupado_out         <= 1'b0;
      lvv_pronto_out      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (expandir_in) begin
            no_q         <= no_atual_in;
            custo_q      <= custo_atual_in;
            idx_q        <= '0;
            ocupado_out  <= 1'b1;
            mem_rd_out   <= 1'b1;
            mem_addr_out <= {no_atual_in, {IDX_WIDTH{1'b0}}};
            state_q      <= StLer;
          end
        end
        StLer: begin
          mem_rd_out <= 1'b0;
          state_q    <= StDado;
        end
        StDado: begin
          if (!mem_valido_in) begin
            // Lists are packed: the first empty slot ends the walk
            lvv_pronto_out <= 1'b1;
            state_q        <= StPronto;
          end else begin
            atualizar_out       <= 1'b1;
            atualizar_addr_out  <= mem_vizinho_in;
            atualizar_custo_out <= soma;
            atualizar_pai_out   <= no_q;
            state_q             <= StEnviar;
          end
        end
        StEnviar: begin
          if (aa_pronto_in) begin
            atualizar_out <= 1'b0;
            if (idx_q == IdxLast) begin
              // Last slot never wraps the index; it always ends the walk
              lvv_pronto_out <= 1'b1;
              state_q        <= StPronto;
            end else begin
              idx_q        <= idx_nxt;
              mem_rd_out   <= 1'b1;
              mem_addr_out <= {no_q, idx_nxt};
              state_q      <= StLer;
            end
          end
        end
        StPronto: begin
          lvv_pronto_out <= 1'b0;
          ocupado_out    <= 1'b0;
          state_q        <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expansor_vizinhos.sv
// Bench for expansor_vizinhos: directed vector table, randomized expansions
// against a slot-list model, and a reset-during-handshake sequence.
module tb_expansor_vizinhos;
  localparam int AW = 8;
  localparam int CW = 10;
  localparam int MV = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          expandir_in = 1'b0;
  logic [AW-1:0] no_atual_in = '0;
  logic [CW-1:0] custo_atual_in = '0;
  logic          mem_rd_out;
  logic [AW+IW-1:0] mem_addr_out;
  logic          mem_valido_in = 1'b0;
  logic [AW-1:0] mem_vizinho_in = '0;
  logic [CW-1:0] mem_peso_in = '0;
  logic          atualizar_out;
  logic [AW-1:0] atualizar_addr_out;
  logic [CW-1:0] atualizar_custo_out;
  logic [AW-1:0] atualizar_pai_out;
  logic          aa_pronto_in = 1'b1;
  logic          ocupado_out;
  logic          lvv_pronto_out;
  logic          saturou_out;

  always #5 clk = ~clk;

  expansor_vizinhos #(
    .ADDR_WIDTH  (AW),
    .COST_WIDTH  (CW),
    .MAX_VIZINHOS(MV)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .expandir_in        (expandir_in),
    .no_atual_in        (no_atual_in),
    .custo_atual_in     (custo_atual_in),
    .mem_rd_out         (mem_rd_out),
    .mem_addr_out       (mem_addr_out),
    .mem_valido_in      (mem_valido_in),
    .mem_vizinho_in     (mem_vizinho_in),
    .mem_peso_in        (mem_peso_in),
    .atualizar_out      (atualizar_out),
    .atualizar_addr_out (atualizar_addr_out),
    .atualizar_custo_out(atualizar_custo_out),
    .atualizar_pai_out  (atualizar_pai_out),
    .aa_pronto_in       (aa_pronto_in),
    .ocupado_out        (ocupado_out),
    .lvv_pronto_out     (lvv_pronto_out),
    .saturou_out        (saturou_out)
  );

  // Neighbour memory: one-cycle read latency, garbage when not read
  logic          vm [0:2047];
  logic [AW-1:0] vv [0:2047];
  logic [CW-1:0] vp [0:2047];

  always @(posedge clk) begin
    if (mem_rd_out) begin
      mem_valido_in  <= vm[mem_addr_out];
      mem_vizinho_in <= vv[mem_addr_out];
      mem_peso_in    <= vp[mem_addr_out];
    end else begin
      mem_valido_in  <= 1'b0;
      mem_vizinho_in <= 8'hee;
      mem_peso_in    <= 10'h3aa;
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [CW-1:0] c;
  } cand_t;

  typedef struct {
    logic [AW-1:0]        node;
    logic [CW-1:0]        cost;
    int                   k;
    logic [7:0][AW-1:0]   viz;
    logic [7:0][CW-1:0]   peso;
    int                   stall0;
    bit                   inject;
    int                   exp_pulse;
    int                   exp_nxfer;
    logic [CW-1:0]        exp_cost0;
    logic                 exp_sat;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int stall_arr [MV];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic load_node(input logic [AW-1:0] node, input int k,
                           input logic [7:0][AW-1:0] viz, input logic [7:0][CW-1:0] peso);
    logic [AW+IW-1:0] a;
    for (int s = 0; s < MV; s++) begin
      a = {node, IW'(s)};
      vm[a] = (s < k);
      vv[a] = viz[s];
      vp[a] = peso[s];
    end
  endtask

  // One expansion; model = the packed slot list read as plain arithmetic
  task automatic run_one(input logic [AW-1:0] node, input logic [CW-1:0] cost, input bit inject,
                         output int pulse_c, output int nx, output logic [CW-1:0] cost0,
                         output logic sat);
    cand_t            exp_q[$];
    logic             sat_exp;
    logic [AW+IW-1:0] a;
    int k, tot, sum, exp_pulse, rd_cnt, ocup_cnt, pulses, cyc, waited, stab_err, cum;
    logic             holding;
    logic [2*AW+CW-1:0] held;

    sat_exp = 1'b0;
    for (int s = 0; s < MV; s++) begin
      a = {node, IW'(s)};
      if (!vm[a]) break;
      sum = int'(cost) + int'(vp[a]);
`ifdef EXPANSOR_SATURACAO_EN
      if (sum > 1023) begin
        sum = 1023;
        sat_exp = 1'b1;
      end
`else
      sum = sum % 1024;
`endif
      exp_q.push_back('{a: vv[a], c: CW'(sum)});
    end
    k = exp_q.size();
    tot = 0;
    for (int m = 0; m < k; m++) tot += stall_arr[m];
    exp_pulse = ((k < MV) ? 3 * k + 3 : 3 * MV + 1) + tot;

    rd_cnt = 0; ocup_cnt = 0; pulses = 0; pulse_c = 0; nx = 0; cost0 = '0;
    waited = 0; stab_err = 0; cum = 0; holding = 1'b0; held = '0; cyc = 0;

    @(negedge clk);
    no_atual_in    = node;
    custo_atual_in = cost;
    expandir_in    = 1'b1;
    aa_pronto_in   = 1'b1;
    while (cyc < 200 && !(pulses > 0 && cyc >= pulse_c + 2)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      expandir_in = 1'b0;
      if (cyc == 1) chk("saturou cleared on start", saturou_out, 0);
      if (mem_rd_out) begin
        chk("read address", mem_addr_out, {node, IW'(rd_cnt)});
        rd_cnt++;
      end
      if (ocupado_out) ocup_cnt++;
      if (lvv_pronto_out) begin
        pulses++;
        pulse_c = cyc;
      end
      if (atualizar_out) begin
        if (holding && {atualizar_addr_out, atualizar_custo_out, atualizar_pai_out} != held)
          stab_err++;
        if (nx < MV && waited < stall_arr[nx]) begin
          aa_pronto_in = 1'b0;
          waited++;
          holding = 1'b1;
          held = {atualizar_addr_out, atualizar_custo_out, atualizar_pai_out};
          if (inject) expandir_in = 1'b1;
        end else begin
          aa_pronto_in = 1'b1;
          holding = 1'b0;
          if (nx < k) begin
            cum += stall_arr[nx];
            chk("xfer addr", atualizar_addr_out, exp_q[nx].a);
            chk("xfer cost", atualizar_custo_out, exp_q[nx].c);
            chk("xfer parent", atualizar_pai_out, node);
            chk("xfer cycle", cyc, 3 * nx + 3 + cum);
            if (nx == 0) cost0 = atualizar_custo_out;
          end else begin
            chk("extra xfer", 1, 0);
          end
          nx++;
          waited = 0;
        end
      end else begin
        aa_pronto_in = 1'($urandom_range(0, 1));
        holding = 1'b0;
      end
    end
    aa_pronto_in = 1'b1;
    chk("pulse count", pulses, 1);
    chk("pulse cycle", pulse_c, exp_pulse);
    chk("xfer count", nx, k);
    chk("read count", rd_cnt, (k < MV) ? k + 1 : MV);
    chk("ocupado cycles", ocup_cnt, exp_pulse);
    chk("held stable", stab_err, 0);
    chk("saturou end", saturou_out, sat_exp);
    sat = saturou_out;
  endtask

  vec_t vt [6];
  int   p_c, n_x;
  logic [CW-1:0] c0;
  logic sat_o;
  logic [7:0][AW-1:0] rv;
  logic [7:0][CW-1:0] rp;
  int   bad;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vm[i] = 1'b0;
      vv[i] = '0;
      vp[i] = '0;
    end

    vt[0] = '{node: 8'd5, cost: 10'd10, k: 2, viz: '0, peso: '0, stall0: 0, inject: 1'b0,
              exp_pulse: 9, exp_nxfer: 2, exp_cost0: 10'd13, exp_sat: 1'b0};
    vt[0].viz[0] = 8'd7; vt[0].peso[0] = 10'd3;
    vt[0].viz[1] = 8'd9; vt[0].peso[1] = 10'd4;
    vt[1] = '{node: 8'd2, cost: 10'd77, k: 0, viz: '0, peso: '0, stall0: 0, inject: 1'b0,
              exp_pulse: 3, exp_nxfer: 0, exp_cost0: 10'd0, exp_sat: 1'b0};
    vt[2] = '{node: 8'd3, cost: 10'd0, k: 8, viz: '0, peso: '0, stall0: 0, inject: 1'b0,
              exp_pulse: 25, exp_nxfer: 8, exp_cost0: 10'd1, exp_sat: 1'b0};
    for (int s = 0; s < MV; s++) begin
      vt[2].viz[s]  = AW'(20 + s);
      vt[2].peso[s] = 10'd1;
    end
    vt[3] = vt[0];
    vt[3].stall0 = 4; vt[3].inject = 1'b1; vt[3].exp_pulse = 13;
    vt[4] = '{node: 8'd1, cost: 10'd1020, k: 1, viz: '0, peso: '0, stall0: 0, inject: 1'b0,
              exp_pulse: 6, exp_nxfer: 1, exp_cost0: 10'd6, exp_sat: 1'b0};
    vt[4].viz[0] = 8'd4; vt[4].peso[0] = 10'd10;
`ifdef EXPANSOR_SATURACAO_EN
    vt[4].exp_cost0 = 10'd1023;
    vt[4].exp_sat   = 1'b1;
`endif
    vt[5] = '{node: 8'd6, cost: 10'd50, k: 1, viz: '0, peso: '0, stall0: 0, inject: 1'b0,
              exp_pulse: 6, exp_nxfer: 1, exp_cost0: 10'd57, exp_sat: 1'b0};
    vt[5].viz[0] = 8'd8; vt[5].peso[0] = 10'd7;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset outputs", {mem_rd_out, mem_addr_out, atualizar_out, atualizar_addr_out,
        atualizar_custo_out, atualizar_pai_out, ocupado_out, lvv_pronto_out, saturou_out}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      for (int m = 0; m < MV; m++) stall_arr[m] = 0;
      stall_arr[0] = vt[i].stall0;
      load_node(vt[i].node, vt[i].k, vt[i].viz, vt[i].peso);
      run_one(vt[i].node, vt[i].cost, vt[i].inject, p_c, n_x, c0, sat_o);
      chk("tbl pulse", p_c, vt[i].exp_pulse);
      chk("tbl nxfer", n_x, vt[i].exp_nxfer);
      if (vt[i].exp_nxfer > 0) chk("tbl cost0", c0, vt[i].exp_cost0);
      chk("tbl saturou", sat_o, vt[i].exp_sat);
    end

    // Randomized expansions
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < MV; s++) begin
        rv[s] = AW'($urandom);
        rp[s] = CW'($urandom);
        stall_arr[s] = $urandom_range(0, 2);
      end
      no_atual_in = AW'($urandom);
      load_node(no_atual_in, $urandom_range(0, MV), rv, rp);
      run_one(no_atual_in, CW'($urandom), 1'($urandom_range(0, 1)), p_c, n_x, c0, sat_o);
    end

    // Reset while a candidate is waiting for the evaluator
    for (int s = 0; s < MV; s++) begin
      rv[s] = AW'(100 + s);
      rp[s] = CW'(s + 1);
      stall_arr[s] = 0;
    end
    load_node(8'd9, 3, rv, rp);
    @(negedge clk);
    no_atual_in    = 8'd9;
    custo_atual_in = 10'd100;
    expandir_in    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      expandir_in  = 1'b0;
      aa_pronto_in = 1'b0;
      if (atualizar_out) break;
    end
    chk("reached enviar", atualizar_out, 1);
    #2 rst = 1'b1;
    #1 chk("async reset outputs", {mem_rd_out, mem_addr_out, atualizar_out, atualizar_addr_out,
        atualizar_custo_out, atualizar_pai_out, ocupado_out, lvv_pronto_out, saturou_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    aa_pronto_in = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (lvv_pronto_out || ocupado_out || atualizar_out) bad++;
    end
    chk("quiet after reset", bad, 0);
    run_one(8'd9, 10'd100, 1'b0, p_c, n_x, c0, sat_o);
    chk("post-reset pulse", p_c, 12);
    chk("post-reset cost0", c0, 10'd101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
